// File: rtl/mux_nw_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_nw_scan_pkg
// Purpose  : Shared constants for the N-channel scanning word mux.
//            - Default width, channel count and dwell length.
//            - Mode encodings for the mode input.
//            - Select-width helper (never narrower than 1 bit).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mux_nw_scan_pkg;

  localparam int MUX_W_DEF     = 8;
  localparam int MUX_N_DEF     = 4;
  localparam int MUX_DWELL_DEF = 4;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to index n items, at least 1 so a single item still gets a port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nw_scan_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Purpose  : Dwell counter and wrap-around channel increment for scan mode.
// Ports    : clk       - system clock
//            rst_n     - synchronous active-low reset
//            en        - 1 = count, 0 = hold the counter
//            scan      - 1 = scan mode active, 0 = counter held at 0
//            cur_sel   - channel currently shown
//            advance   - high when the current channel has used its dwell
//            next_sel  - channel that follows cur_sel (wraps N-1 -> 0)
// Revision : 1.0 - initial release
// ============================================================================
module scan_timer
  import mux_nw_scan_pkg::*;
#(
  parameter  int DWELL = MUX_DWELL_DEF,
  parameter  int N     = MUX_N_DEF,
  localparam int SELW  = sel_width(N),
  localparam int CW    = sel_width(DWELL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            scan,
  input  logic [SELW-1:0] cur_sel,
  output logic            advance,
  output logic [SELW-1:0] next_sel
);

  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);

  logic [CW-1:0] cnt;

  assign advance  = scan && (cnt == LAST_CNT);
  assign next_sel = (cur_sel == LAST_SEL) ? '0 : cur_sel + SELW'(1);

  // Manual mode parks the counter at 0 so a later switch to scan starts a
  // full dwell on whatever channel is showing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (!scan || advance) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_nw_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_nw_scan
// Purpose  : N-channel, W-bit word mux with registered output, manual or
//            auto-scan channel selection, freeze control and change strobe.
// Ports    : clk      - system clock
//            rst_n    - synchronous active-low reset
//            en       - 1 = operate, 0 = freeze all state
//            mode     - 0 = manual select, 1 = auto-scan
//            sel_in   - manual channel select (out-of-range values ignored)
//            x        - packed channel data, channel k at x[k*W +: W]
//            m        - registered selected word
//            sel_out  - channel currently driving m
//            stb      - one-cycle pulse when sel_out takes a new value
// Revision : 1.0 - initial release
// ============================================================================
module mux_nw_scan
  import mux_nw_scan_pkg::*;
#(
  parameter  int W     = MUX_W_DEF,
  parameter  int N     = MUX_N_DEF,
  parameter  int DWELL = MUX_DWELL_DEF,
  localparam int SELW  = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel_in,
  input  logic [N*W-1:0]  x,
  output logic [W-1:0]    m,
  output logic [SELW-1:0] sel_out,
  output logic            stb
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SELW:0] N_LIM = (SELW + 1)'(N);

  logic            advance;
  logic [SELW-1:0] scan_sel;
  logic [SELW-1:0] next_sel;

  scan_timer #(
    .DWELL (DWELL),
    .N     (N)
  ) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .scan     (mode == MODE_SCAN),
    .cur_sel  (sel_out),
    .advance  (advance),
    .next_sel (scan_sel)
  );

  always_comb begin
    next_sel = sel_out;
    if (mode == MODE_SCAN) begin
      if (advance) next_sel = scan_sel;
    end else if ({1'b0, sel_in} < N_LIM) begin
      next_sel = sel_in;
    end
  end

  // m and sel_out load from the same next_sel so they never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m       <= '0;
      sel_out <= '0;
      stb     <= 1'b0;
    end else if (en) begin
      m       <= x[int'(next_sel) * W +: W];
      sel_out <= next_sel;
      stb     <= (next_sel != sel_out);
    end else begin
      stb     <= 1'b0;
    end
  end

endmodule
`default_nettype wire
